// File: rtl/serial_mag_compare_ctrl.sv
// Nibble-serial magnitude compare sequencer.
// Drives a shared 4-bit comparator slice, MSB nibble first, stopping at the first unequal nibble.
module serial_mag_compare_ctrl #(
   parameter int NIBBLES = 4,
   localparam int W = 4 * NIBBLES,
   localparam int CW = $clog2(NIBBLES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  op_a,
   input  logic [W-1:0]  op_b,
   output logic [3:0]    nib_a,
   output logic [3:0]    nib_b,
   input  logic          cmp_gt,
   input  logic          cmp_eq,
   input  logic          cmp_ls,
   output logic          busy,
   output logic          done,
   output logic          gt,
   output logic          eq,
   output logic          ls,
   output logic          err,
   output logic [CW-1:0] ncmp
);

   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   logic [W-1:0]   a_r;
   logic [W-1:0]   b_r;
   logic [IW-1:0]  idx;
   logic [IW-1:0]  nxt;
   logic           onehot;
   logic           last;

   assign nxt = idx - IW'(1);

   always_comb begin
      onehot = (cmp_gt & ~cmp_eq & ~cmp_ls) |
               (~cmp_gt & cmp_eq & ~cmp_ls) |
               (~cmp_gt & ~cmp_eq & cmp_ls);
      // any unequal nibble, a bad flag set, or the LSB nibble ends the scan
      last = ~onehot | cmp_gt | cmp_ls | (idx == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_r   <= '0;
         b_r   <= '0;
         idx   <= '0;
         nib_a <= '0;
         nib_b <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         gt    <= 1'b0;
         eq    <= 1'b0;
         ls    <= 1'b0;
         err   <= 1'b0;
         ncmp  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_r   <= op_a;
                  b_r   <= op_b;
                  idx   <= IW'(NIBBLES - 1);
                  nib_a <= op_a[W-1 -: 4];
                  nib_b <= op_b[W-1 -: 4];
                  gt    <= 1'b0;
                  eq    <= 1'b0;
                  ls    <= 1'b0;
                  err   <= 1'b0;
                  ncmp  <= '0;
                  busy  <= 1'b1;
                  state <= CMP;
               end
            end
            CMP: begin
               ncmp <= ncmp + CW'(1);
               if (last) begin
                  err   <= ~onehot;
                  gt    <= onehot & cmp_gt;
                  eq    <= onehot & cmp_eq;
                  ls    <= onehot & cmp_ls;
                  nib_a <= '0;
                  nib_b <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx   <= nxt;
                  nib_a <= a_r[4*int'(nxt) +: 4];
                  nib_b <= b_r[4*int'(nxt) +: 4];
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Directed bench for serial_mag_compare_ctrl, NIBBLES=4,
// with a behavioural comparator slice that can be forced faulty.
module tb_serial_mag_compare_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [3:0]  nib_a;
   logic [3:0]  nib_b;
   logic        cmp_gt;
   logic        cmp_eq;
   logic        cmp_ls;
   logic        busy;
   logic        done;
   logic        gt;
   logic        eq;
   logic        ls;
   logic        err;
   logic [2:0]  ncmp;
   logic        fault;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // reference 4-bit slice; fault forces an illegal gt+ls pair
   always_comb begin
      cmp_gt = 1'b0;
      cmp_eq = 1'b0;
      cmp_ls = 1'b0;
      if (fault) begin
         cmp_gt = 1'b1;
         cmp_ls = 1'b1;
      end else begin
         cmp_gt = nib_a > nib_b;
         cmp_eq = nib_a == nib_b;
         cmp_ls = nib_a < nib_b;
      end
   end

   serial_mag_compare_ctrl #(.NIBBLES(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op_a   (op_a),
      .op_b   (op_b),
      .nib_a  (nib_a),
      .nib_b  (nib_b),
      .cmp_gt (cmp_gt),
      .cmp_eq (cmp_eq),
      .cmp_ls (cmp_ls),
      .busy   (busy),
      .done   (done),
      .gt     (gt),
      .eq     (eq),
      .ls     (ls),
      .err    (err),
      .ncmp   (ncmp)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // packs {busy,done,gt,eq,ls,err} for compact checks
   function automatic logic [5:0] st();
      return {busy, done, gt, eq, ls, err};
   endfunction

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      fault = 1'b0;
      tick();
      tick();
      chk("reset_flags", st(), 6'b000000);
      chk("reset_ncmp", ncmp, 0);
      chk("reset_nib", {nib_a, nib_b}, 8'h00);
      rst = 1'b0;
      tick();

      // test 1: equal operands, full scan
      start = 1'b1; op_a = 16'h1234; op_b = 16'h1234;
      tick();
      start = 1'b0;
      chk("t1_busy0", st(), 6'b100000);
      chk("t1_nib0", {nib_a, nib_b}, 8'h11);
      tick();
      chk("t1_nib1", {nib_a, nib_b}, 8'h22);
      tick();
      tick();
      chk("t1_busy3", st(), 6'b100000);
      chk("t1_nib3", {nib_a, nib_b}, 8'h44);
      tick();
      chk("t1_done", st(), 6'b010100);
      chk("t1_ncmp", ncmp, 4);
      chk("t1_nib_idle", {nib_a, nib_b}, 8'h00);
      tick();
      chk("t1_hold", st(), 6'b000100);
      chk("t1_hold_ncmp", ncmp, 4);
      tick();

      // test 2: first nibble decides
      start = 1'b1; op_a = 16'h9000; op_b = 16'h8FFF;
      tick();
      start = 1'b0;
      chk("t2_busy", st(), 6'b100000);
      chk("t2_nib", {nib_a, nib_b}, 8'h98);
      tick();
      chk("t2_done", st(), 6'b011000);
      chk("t2_ncmp", ncmp, 1);
      tick();

      // test 3: last nibble less, then zeros equal
      start = 1'b1; op_a = 16'h1230; op_b = 16'h1231;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("t3a_busy", st(), 6'b100000);
      tick();
      chk("t3a_done", st(), 6'b010010);
      chk("t3a_ncmp", ncmp, 4);
      tick();
      start = 1'b1; op_a = 16'h0000; op_b = 16'h0000;
      tick();
      start = 1'b0;
      chk("t3b_clr", st(), 6'b100000);
      tick(); tick(); tick(); tick();
      chk("t3b_done", st(), 6'b010100);
      chk("t3b_ncmp", ncmp, 4);
      tick();

      // test 4: start while busy and during DONE is ignored
      start = 1'b1; op_a = 16'h1234; op_b = 16'h1200;
      tick();
      op_a = 16'h0000; op_b = 16'hFFFF;
      tick();
      chk("t4_busy", st(), 6'b100000);
      tick();
      start = 1'b0;
      tick();
      chk("t4_done", st(), 6'b011000);
      chk("t4_ncmp", ncmp, 3);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_done_start", st(), 6'b001000);
      tick();
      chk("t4_still_idle", st(), 6'b001000);

      // test 5: illegal flag pair from slice
      fault = 1'b1;
      start = 1'b1; op_a = 16'h5555; op_b = 16'h5555;
      tick();
      start = 1'b0;
      tick();
      chk("t5_err", st(), 6'b010001);
      chk("t5_ncmp", ncmp, 1);
      fault = 1'b0;
      tick();

      // test 6: reset on second compare cycle
      start = 1'b1; op_a = 16'h1234; op_b = 16'h1234;
      tick();
      start = 1'b0;
      tick();
      chk("t6_mid", {nib_a, nib_b}, 8'h22);
      rst = 1'b1;
      tick();
      chk("t6_flags", st(), 6'b000000);
      chk("t6_ncmp", ncmp, 0);
      chk("t6_nib", {nib_a, nib_b}, 8'h00);
      rst = 1'b0;
      tick(); tick(); tick();
      chk("t6_no_done", st(), 6'b000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
